// File: rtl/ppu_ctrl_pkg.sv
// ppu_ctrl_pkg: shared definitions for the PPU control-vector interface.
// Field bit indices of the 22-bit decoder vector, forward-select encodings,
// the NOP vector, the per-stage payload struct and small decode helpers.
// Used by both the decoder and the control pipeline.
package ppu_ctrl_pkg;

  localparam int unsigned CW    = 22;
  localparam int unsigned REG_W = 5;

  // Control vector field positions, LSB first
  localparam int unsigned EN_LO_BIT     = 0;
  localparam int unsigned EN_HI_BIT     = 1;
  localparam int unsigned MEM_EN_BIT    = 2;
  localparam int unsigned MEM_SE_BIT    = 3;
  localparam int unsigned MEM_RW_BIT    = 4;
  localparam int unsigned MEM_SIZE_LSB  = 5;
  localparam int unsigned MEM_SIZE_MSB  = 6;
  localparam int unsigned TA_BIT        = 7;
  localparam int unsigned RF_EN_BIT     = 8;
  localparam int unsigned LOAD_BIT      = 9;
  localparam int unsigned B_BIT         = 10;
  localparam int unsigned ALU_OP_LSB    = 11;
  localparam int unsigned ALU_OP_MSB    = 14;
  localparam int unsigned SRC_OP_LSB    = 15;
  localparam int unsigned SRC_OP_MSB    = 17;
  localparam int unsigned DEST_REG_BIT  = 18;
  localparam int unsigned UJ_BIT        = 19;
  localparam int unsigned R31_BIT       = 20;
  localparam int unsigned CUJ_BIT       = 21;

  typedef logic [CW-1:0]    ctrl_vec_t;
  typedef logic [REG_W-1:0] reg_idx_t;

  localparam ctrl_vec_t CTRL_NOP = '0;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_t;

  // One pipeline stage register: control vector plus resolved destination
  typedef struct packed {
    ctrl_vec_t ctrl;
    reg_idx_t  dest;
  } stage_t;

  localparam stage_t STAGE_NOP = '0;

  // A real memory load; LOAD alone also marks immediate ALU ops
  function automatic logic is_qual_load(input ctrl_vec_t c);
    return c[LOAD_BIT] & c[MEM_EN_BIT];
  endfunction

  // Stage produces a register-file write to a non-zero register
  function automatic logic writes_reg(input ctrl_vec_t c, input reg_idx_t d);
    return c[RF_EN_BIT] & (d != '0);
  endfunction

endpackage

// File: rtl/ppu_hazard_fwd.sv
// ppu_hazard_fwd: combinational load-use hazard detection and operand
// forwarding selects for the ID stage.
// Ports:
//   id_rs_i / id_rt_i                : source registers of the ID instruction
//   {ex,mem,wb}_ctrl_i / _dest_i     : current stage register contents
//   load_use_c_o                     : EX holds a load feeding an ID source
//   fwd_a_c_o / fwd_b_c_o            : operand select for rs / rt
module ppu_hazard_fwd
  import ppu_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic [CW-1:0]    ex_ctrl_i,
  input  logic [REG_W-1:0] ex_dest_i,
  input  logic [CW-1:0]    mem_ctrl_i,
  input  logic [REG_W-1:0] mem_dest_i,
  input  logic [CW-1:0]    wb_ctrl_i,
  input  logic [REG_W-1:0] wb_dest_i,
  output logic             load_use_c_o,
  output logic [1:0]       fwd_a_c_o,
  output logic [1:0]       fwd_b_c_o
);

  logic ex_wr;
  logic ex_ld;
  logic mem_wr;
  logic wb_wr;

  // Priority EX > MEM > WB; a load in EX has no data yet, so skip it
  function automatic fwd_sel_t pick(input reg_idx_t src,
                                    input logic ex_ok, input reg_idx_t ex_d,
                                    input logic mem_ok, input reg_idx_t mem_d,
                                    input logic wb_ok, input reg_idx_t wb_d);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (src == '0)                       sel = FWD_RF;
    else if (ex_ok && (ex_d == src))     sel = FWD_EX;
    else if (mem_ok && (mem_d == src))   sel = FWD_MEM;
    else if (wb_ok && (wb_d == src))     sel = FWD_WB;
    return sel;
  endfunction

  always_comb begin
    ex_wr  = writes_reg(ex_ctrl_i, ex_dest_i);
    ex_ld  = is_qual_load(ex_ctrl_i);
    mem_wr = writes_reg(mem_ctrl_i, mem_dest_i);
    wb_wr  = writes_reg(wb_ctrl_i, wb_dest_i);

    load_use_c_o = ex_wr & ex_ld &
                   ((ex_dest_i == id_rs_i) | (ex_dest_i == id_rt_i));

    fwd_a_c_o = 2'(pick(id_rs_i, ex_wr & ~ex_ld, ex_dest_i,
                        mem_wr, mem_dest_i, wb_wr, wb_dest_i));
    fwd_b_c_o = 2'(pick(id_rt_i, ex_wr & ~ex_ld, ex_dest_i,
                        mem_wr, mem_dest_i, wb_wr, wb_dest_i));
  end

endmodule

// File: rtl/ppu_ctrl_pipeline.sv
// ppu_ctrl_pipeline: carries the decoder control vector through the EX, MEM
// and WB pipeline registers, inserting bubbles on load-use hazards and on
// redirect flushes, and exposes the ID-stage stall and forwarding selects.
// Ports:
//   clk, reset (async, active-high)
//   id_ctrl/id_rs/id_rt/id_dest  : instruction currently in ID
//   flush                        : redirect resolved, squash ID
//   {ex,mem,wb}_ctrl/_dest       : registered stage contents
//   stall, fwd_a, fwd_b          : combinational ID-stage controls
//   bubble_cnt                   : saturating count of inserted bubbles
module ppu_ctrl_pipeline
  import ppu_ctrl_pkg::*;
#(
  parameter int unsigned CW    = ppu_ctrl_pkg::CW,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CW-1:0]    id_ctrl,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_dest,
  input  logic             flush,
  output logic [CW-1:0]    ex_ctrl,
  output logic [CW-1:0]    mem_ctrl,
  output logic [CW-1:0]    wb_ctrl,
  output logic [4:0]       ex_dest,
  output logic [4:0]       mem_dest,
  output logic [4:0]       wb_dest,
  output logic             stall,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] bubble_cnt
);

  stage_t ex_q, ex_d;
  stage_t mem_q, mem_d;
  stage_t wb_q, wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       load_use_c;
  logic [1:0] fwd_a_c;
  logic [1:0] fwd_b_c;
  logic       bubble_c;

  ppu_hazard_fwd u_hazard_fwd (
    .id_rs_i      (id_rs),
    .id_rt_i      (id_rt),
    .ex_ctrl_i    (ex_q.ctrl),
    .ex_dest_i    (ex_q.dest),
    .mem_ctrl_i   (mem_q.ctrl),
    .mem_dest_i   (mem_q.dest),
    .wb_ctrl_i    (wb_q.ctrl),
    .wb_dest_i    (wb_q.dest),
    .load_use_c_o (load_use_c),
    .fwd_a_c_o    (fwd_a_c),
    .fwd_b_c_o    (fwd_b_c)
  );

  // Flush and load-use both produce a single bubble; flush suppresses stall
  always_comb begin
    bubble_c = flush | load_use_c;

    ex_d.ctrl = id_ctrl;
    ex_d.dest = id_dest;
    if (bubble_c) ex_d = STAGE_NOP;

    // MEM and WB advance unconditionally
    mem_d = ex_q;
    wb_d  = mem_q;

    cnt_d = cnt_q;
    if (bubble_c && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  // Stage registers and bubble counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= STAGE_NOP;
      mem_q <= STAGE_NOP;
      wb_q  <= STAGE_NOP;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  // ID-stage controls are quiet while reset is held
  always_comb begin
    stall = load_use_c & ~flush & ~reset;
    fwd_a = reset ? 2'b00 : fwd_a_c;
    fwd_b = reset ? 2'b00 : fwd_b_c;
  end

  assign ex_ctrl    = ex_q.ctrl;
  assign ex_dest    = ex_q.dest;
  assign mem_ctrl   = mem_q.ctrl;
  assign mem_dest   = mem_q.dest;
  assign wb_ctrl    = wb_q.ctrl;
  assign wb_dest    = wb_q.dest;
  assign bubble_cnt = cnt_q;

endmodule

// File: doc/ppu_ctrl_pipeline.md
# ppu_ctrl_pipeline

Carries the 22-bit control vector produced by `PPU_Control_Unit` from ID through the EX, MEM and WB pipeline registers of the PPU. It also detects load-use hazards, inserts bubbles, squashes on redirect, and generates operand-forwarding selects for the ID stage. It is the consuming end of the control-vector interface: every field the decoder packs is unpacked and acted on here or passed downstream.

## Interface
Parameters:
- `CW`, 22, control-vector width. Fixed by the decoder packing; not to be overridden.
- `CNT_W`, 16, width of the bubble counter.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high.
- `id_ctrl` in 22: control vector from the decoder. All zeros means NOP.
- `id_rs`, `id_rt` in 5 each: source register numbers of the instruction in ID.
- `id_dest` in 5: resolved destination register (rd, rt or 31) of the instruction in ID.
- `flush` in 1: taken branch or jump resolved this cycle; squash the instruction in ID.
- `ex_ctrl`, `mem_ctrl`, `wb_ctrl` out 22 each: registered control vectors per stage.
- `ex_dest`, `mem_dest`, `wb_dest` out 5 each: registered destination register per stage.
- `stall` out 1: hold PC and IF/ID this cycle.
- `fwd_a`, `fwd_b` out 2 each: operand select for rs and rt. 00 = register file, 01 = EX, 10 = MEM, 11 = WB.
- `bubble_cnt` out `CNT_W`: saturating count of inserted bubbles.

## Operation
- Vector bit map, from LSB:
  - 0 EN_LO, 1 EN_HI, 2 MEM_EN, 3 MEM_SE, 4 MEM_RW, 6:5 MEM_SIZE, 7 TA
  - 8 RF_EN, 9 LOAD, 10 B, 14:11 ALU_OP, 17:15 SRC_OP
  - 18 DEST_REG, 19 UJ, 20 R31, 21 CUJ
- Load qualifier: `LOAD & MEM_EN`. LOAD alone is not sufficient, because immediate ALU ops also set it.
- Stage writes a register: `RF_EN` = 1 and dest ≠ 0.
- Load-use hazard:
  - Condition: EX holds a qualified load that writes a register, and `ex_dest` equals `id_rs` or `id_rt`.
  - Response: `stall` = 1; EX is loaded with all zeros (bubble); `bubble_cnt` increments.
- Flush:
  - EX is loaded with zeros; `id_dest` is discarded; `bubble_cnt` increments.
  - `stall` is forced to 0, so flush wins over stall.
- Normal cycle: EX ← (`id_ctrl`, `id_dest`); MEM ← EX; WB ← MEM.
  - MEM and WB always advance; a stall never freezes them.
- Forwarding, evaluated independently for rs (`fwd_a`) and rt (`fwd_b`):
  - Priority EX > MEM > WB. A stage matches if it writes a register and its dest equals the source number.
  - EX is never selected when it holds a qualified load; fall through to MEM/WB. The stall covers that case anyway.
  - Source register 0 always yields 00.
- `bubble_cnt` saturates at all-ones and never wraps.
- The block is a three-deep shift pipeline with one combinational hazard/forward unit. There is no FSM.

## Timing
- Reset (async, immediate): all stage vectors and dests read 0, `bubble_cnt` = 0. While reset is held, `stall` = 0 and `fwd_*` = 00.
- Latency: `id_ctrl` at edge N appears on `ex_ctrl` after N, on `mem_ctrl` after N+1, and on `wb_ctrl` after N+2.
- `stall` and `fwd_*` are combinational from the ID inputs and the registered stage state, within the same cycle. No registered delay.
- A load-use stall lasts exactly one cycle. The next cycle the load is in MEM, the hazard clears, and `fwd` selects 10.
- Reset deasserted mid-stream: first edge after deassert captures `id_ctrl` normally. No residual bubbles.
- `flush` and hazard in the same cycle: exactly one bubble, `stall` = 0, counter +1 (not +2).
- Counter at max with a bubble event: stays at max.

## Structure
- Package `ppu_ctrl_pkg`:
  - Bit-index localparams for every field in the map above.
  - `CW` = 22.
  - Forward-select encodings `FWD_RF`/`FWD_EX`/`FWD_MEM`/`FWD_WB`.
  - A NOP vector constant.
  - The decoder migrates to the same package.
- Sub-module `ppu_hazard_fwd`: purely combinational, producing `stall` and `fwd_a`/`fwd_b` from the ID sources and the three stage (ctrl, dest) pairs.
- The top level holds the stage registers and the counter.

## Test plan
- Reset then ADDIU-type vector `0x20300`, `id_dest` = 5, pushed once → appears on `ex_ctrl`, `mem_ctrl`, `wb_ctrl` on three successive edges, with dest 5 each time.
- LBU vector `0x20304`, dest 8, followed by `id_rs` = 8:
  - `stall` = 1 for one cycle; `ex_ctrl` = 0 next; `bubble_cnt` = 1.
  - Following cycle: `fwd_a` = 10.
- Back-to-back writers to r9 (EX and MEM both dest 9), `id_rt` = 9 → `fwd_b` = 01. With `id_rt` = 0 → `fwd_b` = 00.
- `flush` = 1 with `id_ctrl` = JAL `0x3E6100` → `ex_ctrl` = 0 next edge, `stall` = 0, `bubble_cnt` +1. With a load-use hazard present in the same cycle, still +1.
- Force `bubble_cnt` to 0xFFFF via 65535 flushes, then flush again → `bubble_cnt` stays 0xFFFF.
- Assert `reset` asynchronously between edges while all stages are non-zero → all outputs 0 immediately, before the next clock edge.
